// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bundle around lsu_mem_ctrl. The datapath plus the
// word-addressed memory form the master side; the load/store controller is the slave.
interface lsu_mem_ctrl_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DWIDTH-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [DWIDTH-1:0] resp_rdata;

    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wr_data;
    logic [DWIDTH-1:0] mem_rd_data;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_err, resp_rdata,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_err, resp_rdata,
        output mem_wr_en, mem_rd_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// MIPS32 load/store initiator: turns one byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw request
// into word accesses on a word-addressed memory, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    lsu_mem_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RSP  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state;

    logic              req_we_q;
    logic [1:0]        req_size_q;
    logic              req_signed_q;
    logic [1:0]        req_off_q;
    logic [DWIDTH-1:0] req_wdata_q;

    logic              resp_err_q;
    logic [DWIDTH-1:0] resp_rdata_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wr_data_q;

    logic              accept;
    logic              req_bad;
    logic              unused_addr_bits;

    // Reserved size, or an access that would straddle its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane pick followed by sign or zero extension.
    function automatic logic [DWIDTH-1:0] load_extract(
        input logic [DWIDTH-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        off,
        input logic              sgn
    );
        logic [7:0]        lane_b;
        logic [15:0]       lane_h;
        logic [DWIDTH-1:0] res;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_HALF: res = {{16{sgn & lane_h[15]}}, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // New lane(s) replace the old ones; the rest of the word is carried over.
    function automatic logic [DWIDTH-1:0] store_merge(
        input logic [DWIDTH-1:0] old_word,
        input logic [DWIDTH-1:0] wdata,
        input logic [1:0]        size,
        input logic [1:0]        off
    );
        logic [DWIDTH-1:0] res;
        res = old_word;
        if (size == SZ_BYTE) begin
            res[{off, 3'b000} +: 8] = wdata[7:0];
        end else begin
            res[{off[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return res;
    endfunction

    assign accept  = (state == IDLE) && bus.req_valid;
    assign req_bad = is_misaligned(bus.req_size, bus.req_addr[1:0]);

    // Bits above the memory window are intentionally ignored.
    assign unused_addr_bits = ^bus.req_addr[31:AWIDTH+2];

    // Request capture: only the fields later states need; no reset, qualified by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_q     <= bus.req_we;
            req_size_q   <= bus.req_size;
            req_signed_q <= bus.req_signed;
            req_off_q    <= bus.req_addr[1:0];
            req_wdata_q  <= bus.req_wdata;
        end
    end

    // Control FSM and the registered outputs it owns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        mem_addr_q <= bus.req_addr[AWIDTH+1:2];
                        if (req_bad) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RSP;
                        end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            mem_wr_data_q <= bus.req_wdata;
                            state         <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (req_we_q) begin
                        mem_wr_data_q <= store_merge(bus.mem_rd_data, req_wdata_q,
                                                     req_size_q, req_off_q);
                        state         <= WR;
                    end else begin
                        resp_rdata_q <= load_extract(bus.mem_rd_data, req_size_q,
                                                     req_off_q, req_signed_q);
                        resp_err_q   <= 1'b0;
                        state        <= RSP;
                    end
                end
                WR: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state        <= RSP;
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so they are flat across the whole cycle.
    assign bus.req_ready   = rstn && (state == IDLE);
    assign bus.resp_valid  = (state == RSP);
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.mem_rd_en   = (state == RD);
    assign bus.mem_wr_en   = (state == WR);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: a word memory model on the bus plus a transaction-level
// reference (array of words, lane arithmetic) predicting strobes, latency and response.
module tb_lsu_mem_ctrl;
    localparam int AWIDTH = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.AWIDTH(AWIDTH), .DWIDTH(32)) bus ();

    lsu_mem_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        seeded = 1'b0;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Data memory: write on posedge, read data presented the cycle after mem_rd_en.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            seeded <= 1'b1;
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
            if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Invariants that must hold on every cycle out of reset.
    always @(negedge clk) begin
        if (rstn && seeded) begin
            chk("resp_vs_ready", {31'd0, bus.resp_valid & bus.req_ready}, 32'd0);
            chk("rd_vs_wr", {31'd0, bus.mem_rd_en & bus.mem_wr_en}, 32'd0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   {31'd0, bus.req_ready},   32'd0);
        chk({tag, "_resp_valid"},  {31'd0, bus.resp_valid},  32'd0);
        chk({tag, "_resp_err"},    {31'd0, bus.resp_err},    32'd0);
        chk({tag, "_resp_rdata"},  bus.resp_rdata,           32'd0);
        chk({tag, "_mem_wr_en"},   {31'd0, bus.mem_wr_en},   32'd0);
        chk({tag, "_mem_rd_en"},   {31'd0, bus.mem_rd_en},   32'd0);
        chk({tag, "_mem_addr"},    {22'd0, bus.mem_addr},    32'd0);
        chk({tag, "_mem_wr_data"}, bus.mem_wr_data,          32'd0);
    endtask

    // One transaction: predict from the reference memory, drive, observe every cycle, compare.
    task automatic do_req(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  bit          junk,
        output logic [31:0] got_rdata,
        output logic [31:0] got_wdata,
        output logic        got_err
    );
        logic [9:0]  widx;
        int          sh;
        bit          err;
        logic [31:0] old_w, lane, mask, exp_rdata, exp_wdata;
        int          exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt, wait_cyc;

        widx  = addr[11:2];
        sh    = 8 * int'(addr[1:0]);
        err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        old_w = ref_mem[widx];
        mask  = (size == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
        exp_rdata = 32'd0;
        exp_wdata = 32'd0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            if (size == 2'd2) begin
                exp_rdata = old_w;
            end else begin
                lane = (old_w & mask) >> sh;
                if (size == 2'd0) exp_rdata = (sgn && lane >= 32'h80)   ? (lane | 32'hFFFFFF00) : lane;
                else              exp_rdata = (sgn && lane >= 32'h8000) ? (lane | 32'hFFFF0000) : lane;
            end
        end else if (size == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            exp_wdata = wdata;
        end else begin
            exp_lat = 4; exp_rd = 1; exp_wr = 1;
            exp_wdata = (old_w & ~mask) | ((wdata << sh) & mask);
        end

        wait_cyc = 0;
        while (!bus.req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        if (junk) begin
            bus.req_we    = $urandom_range(0, 1) == 1;
            bus.req_size  = 2'($urandom_range(0, 3));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end

        got_rdata = 32'd0; got_wdata = 32'd0; got_err = 1'b0;
        lat = 0; rd_cnt = 0; wr_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                rd_cnt++;
                chk("rd_addr", {22'd0, bus.mem_addr}, {22'd0, widx});
            end
            if (bus.mem_wr_en) begin
                wr_cnt++;
                got_wdata = bus.mem_wr_data;
                chk("wr_addr", {22'd0, bus.mem_addr}, {22'd0, widx});
                chk("wr_data", got_wdata, exp_wdata);
            end
            if (bus.resp_valid) begin
                lat = c;
                got_rdata = bus.resp_rdata;
                got_err   = bus.resp_err;
                chk("resp_err", {31'd0, got_err}, {31'd0, err});
                chk("resp_rdata", got_rdata, exp_rdata);
                break;
            end
            chk("busy_not_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        chk("latency", lat, exp_lat);
        chk("rd_strobes", rd_cnt, exp_rd);
        chk("wr_strobes", wr_cnt, exp_wr);
        bus.req_valid = 1'b0;

        @(negedge clk);
        chk("ready_after", {31'd0, bus.req_ready}, 32'd1);
        chk("resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
        chk("err_hold", {31'd0, bus.resp_err}, {31'd0, err});
        chk("rdata_hold", bus.resp_rdata, exp_rdata);
        if (!err && we) ref_mem[widx] = exp_wdata;
        chk("mem_word", mem[widx], ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] rd, wd;
        logic        er;
        logic [31:0] saved;
        int          wr_seen, rsp_seen, mism;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        // Power-up reset
        #1 rstn = 1'b0;
        #1 chk_reset_outputs("rst_por");
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        #1 chk("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);

        // sw / lw round trip
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, wd, er);
        chk("sw_wdata_lit", wd, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd, er);
        chk("lw_lit", rd, 32'hDEADBEEF);

        // Extension and lane select
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 1'b0, rd, wd, er);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, rd, wd, er);
        chk("lb_lit", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, rd, wd, er);
        chk("lbu_lit", rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, rd, wd, er);
        chk("lh_lit", rd, 32'hFFFF80FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd, er);
        chk("lhu_lit", rd, 32'h00007F01);

        // Sub-word read-modify-write
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, rd, wd, er);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0, rd, wd, er);
        chk("sb_merge_lit", wd, 32'h1122AA44);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b0, rd, wd, er);
        chk("sh_merge_lit", wd, 32'hBEEFAA44);

        // Reset during CAP of a sub-word store
        saved = ref_mem[4];
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_addr = 32'h11; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        wr_seen = 0; rsp_seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        #1 chk("abort_release_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_wr_en) wr_seen++;
            if (bus.resp_valid) rsp_seen++;
        end
        chk("abort_no_wr", wr_seen, 0);
        chk("abort_no_resp", rsp_seen, 0);
        chk("abort_mem_kept", mem[4], saved);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd, er);
        chk("post_abort_lw_lit", rd, 32'hBEEFAA44);

        // Errors, and a request held valid while a store is busy
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0, rd, wd, er);
        chk("lw_mis_err_lit", {31'd0, er}, 32'd1);
        chk("lw_mis_rdata_lit", rd, 32'd0);
        do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b0, rd, wd, er);
        chk("lh_mis_err_lit", {31'd0, er}, 32'd1);
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 1'b0, rd, wd, er);
        chk("size3_err_lit", {31'd0, er}, 32'd1);
        do_req(1'b1, 2'd0, 1'b0, 32'h17, 32'h000000C3, 1'b1, rd, wd, er);
        do_req(1'b1, 2'd2, 1'b0, 32'h18, 32'h0BADF00D, 1'b1, rd, wd, er);

        // Randomized traffic, concentrated on a few words to force read-after-write reuse
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'h3F;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom,
                   $urandom_range(0, 1) == 1, rd, wd, er);
        end

        // Mid-cycle reset from idle, then full memory image against the reference
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk_reset_outputs("rst_idle");
        @(negedge clk) rstn = 1'b1;
        #1 chk("rst_idle_release_ready", {31'd0, bus.req_ready}, 32'd1);
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
